// File: rtl/an_tone_keyer_pkg.sv
// Shared constants, state codes and parameter-derivation helpers for the keyed tone source.
package an_tone_keyer_pkg;

    localparam int unsigned SMPL_W = 16;
    localparam int unsigned ENV_W  = 8;
    localparam int unsigned ENV_EW = ENV_W + 1;
    localparam int unsigned ST_W   = 2;

    localparam logic [ST_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [ST_W-1:0] ST_ATTACK  = 2'd1;
    localparam logic [ST_W-1:0] ST_SUSTAIN = 2'd2;
    localparam logic [ST_W-1:0] ST_RELEASE = 2'd3;

    localparam logic [ENV_W-1:0]  ENV_MAX = {ENV_W{1'b1}};
    localparam logic [SMPL_W-1:0] TRI_POS = {1'b0, {(SMPL_W-1){1'b1}}};
    localparam logic [SMPL_W-1:0] TRI_OFS = {1'b1, {(SMPL_W-1){1'b0}}};

    // Number of bits needed to hold the values 0..n-1 (at least 1).
    function automatic int unsigned bits_for(input longint unsigned n);
        int unsigned b;
        b = 1;
        while (b < 63 && (64'd1 << b) < n) begin
            b = b + 1;
        end
        return b;
    endfunction

    // Clock cycles per sample tick, floored.
    function automatic int unsigned tick_n_f(input longint unsigned ck_fs,
                                             input longint unsigned smpl_fs);
        return 32'(ck_fs / smpl_fs);
    endfunction

    // Phase increment per tick, rounded to nearest: round(tone * 2^ph_w / smpl).
    function automatic longint unsigned ph_inc_f(input longint unsigned tone_fs,
                                                 input longint unsigned smpl_fs,
                                                 input int unsigned     ph_w);
        longint unsigned num;
        num = tone_fs << ph_w;
        return (2 * num + smpl_fs) / (2 * smpl_fs);
    endfunction

endpackage

// File: rtl/an_tone_keyer_key_deb.sv
// Raw key synchroniser and debouncer: output follows the synced key only after it has
// disagreed with the output for C_DEB_CKN consecutive cycles.
module an_tone_keyer_key_deb
    import an_tone_keyer_pkg::*;
#(
    parameter int unsigned C_DEB_CKN = 1_350_000
)(
    input  logic CK_i,
    input  logic XARST_i,
    input  logic KEY_i,
    output logic KEY_ON_o
);

    localparam int unsigned      CNT_W    = bits_for(64'(C_DEB_CKN));
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_DEB_CKN - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_key_on;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= KEY_i;
            r_sync2 <= r_sync1;
        end
    end

    // Any cycle of agreement restarts the count, so short glitches never reach the output.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            r_cnt    <= '0;
            r_key_on <= 1'b0;
        end else if (r_sync2 == r_key_on) begin
            r_cnt    <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt    <= '0;
            r_key_on <= ~r_key_on;
        end else begin
            r_cnt    <= r_cnt + CNT_W'(1);
        end
    end

    assign KEY_ON_o = r_key_on;

endmodule

// File: rtl/an_tone_keyer.sv
// Keyed tone source: debounced key drives an attack/sustain/release envelope at the sample
// rate; enveloped triangle samples leave over a valid/ready handshake with sticky overrun.
module an_tone_keyer
    import an_tone_keyer_pkg::*;
#(
    parameter int unsigned C_CK_Fs    = 135_000_000,
    parameter int unsigned C_SMPL_Fs  = 48_000,
    parameter int unsigned C_TONE_Fs  = 440,
    parameter int unsigned C_PH_W     = 24,
    parameter int unsigned C_DEB_CKN  = 1_350_000,
    parameter int unsigned C_ENV_STEP = 4
)(
    input  logic              CK_i,
    input  logic              XARST_i,
    input  logic              KEY_i,
    input  logic              MUTE_i,
    output logic [SMPL_W-1:0] SMPL_o,
    output logic              SMPL_VLD_o,
    input  logic              SMPL_RDY_i,
    output logic              OVR_o,
    output logic              KEY_ON_o,
    output logic [ENV_W-1:0]  ENV_o,
    output logic [ST_W-1:0]   STATE_o
);

    localparam int unsigned       C_TICK_N  = tick_n_f(64'(C_CK_Fs), 64'(C_SMPL_Fs));
    localparam int unsigned       TICK_W    = bits_for(64'(C_TICK_N));
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(C_TICK_N - 1);
    localparam logic [C_PH_W-1:0] C_PH_INC  =
        C_PH_W'(ph_inc_f(64'(C_TONE_Fs), 64'(C_SMPL_Fs), C_PH_W));
    localparam logic [ENV_EW-1:0] ENV_STEP  = ENV_EW'(C_ENV_STEP);

    logic                      w_key_on;
    logic                      w_tick;
    logic [TICK_W-1:0]         r_tick_cnt;
    logic                      r_tick_d1;
    logic                      r_tick_d2;

    logic [ST_W-1:0]           r_state;
    logic [ST_W-1:0]           w_state_nxt;
    logic [ENV_W-1:0]          r_env;
    logic [ENV_W-1:0]          w_env_nxt;
    logic [C_PH_W-1:0]         r_phase;
    logic [C_PH_W-1:0]         w_phase_nxt;
    logic [ENV_EW-1:0]         w_env_up;
    logic [ENV_EW-1:0]         w_env_dn;

    logic [SMPL_W-1:0]         w_u;
    logic [SMPL_W-1:0]         w_tri;
    logic signed [SMPL_W+ENV_W:0] w_prod;
    logic [SMPL_W-1:0]         r_prod;

    logic [SMPL_W-1:0]         r_smpl;
    logic                      r_vld;
    logic                      r_ovr;

    an_tone_keyer_key_deb #(
        .C_DEB_CKN (C_DEB_CKN)
    ) u_key_deb (
        .CK_i      (CK_i),
        .XARST_i   (XARST_i),
        .KEY_i     (KEY_i),
        .KEY_ON_o  (w_key_on)
    );

    // Sample-rate tick: one cycle out of every C_TICK_N.
    assign w_tick = (r_tick_cnt == TICK_LAST);

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            r_tick_cnt <= '0;
            r_tick_d1  <= 1'b0;
            r_tick_d2  <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TICK_W'(1);
            r_tick_d1  <= w_tick;
            r_tick_d2  <= r_tick_d1;
        end
    end

    assign w_env_up = ENV_EW'(r_env) + ENV_STEP;
    assign w_env_dn = ENV_EW'(r_env) - ENV_STEP;

    // Envelope FSM next state; everything holds between ticks.
    always_comb begin
        w_state_nxt = r_state;
        w_env_nxt   = r_env;
        w_phase_nxt = r_phase;
        if (w_tick) begin
            case (r_state)
                ST_IDLE: begin
                    w_env_nxt   = '0;
                    w_phase_nxt = '0;
                    if (w_key_on) begin
                        w_state_nxt = ST_ATTACK;
                    end
                end
                ST_ATTACK: begin
                    w_phase_nxt = r_phase + C_PH_INC;
                    if (!w_key_on) begin
                        w_state_nxt = ST_RELEASE;
                    end else if (w_env_up[ENV_W] || w_env_up[ENV_W-1:0] == ENV_MAX) begin
                        w_env_nxt   = ENV_MAX;
                        w_state_nxt = ST_SUSTAIN;
                    end else begin
                        w_env_nxt   = w_env_up[ENV_W-1:0];
                    end
                end
                ST_SUSTAIN: begin
                    w_phase_nxt = r_phase + C_PH_INC;
                    w_env_nxt   = ENV_MAX;
                    if (!w_key_on) begin
                        w_state_nxt = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    w_phase_nxt = r_phase + C_PH_INC;
                    if (w_key_on) begin
                        w_state_nxt = ST_ATTACK;
                    end else if (w_env_dn[ENV_W] || w_env_dn[ENV_W-1:0] == '0) begin
                        // Borrow out of bit ENV_W means the step overshot zero.
                        w_env_nxt   = '0;
                        w_phase_nxt = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_env_nxt   = w_env_dn[ENV_W-1:0];
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_env_nxt   = '0;
                    w_phase_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            r_state <= ST_IDLE;
            r_env   <= '0;
            r_phase <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_env   <= w_env_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    // Triangle from the phase: rising half below the MSB midpoint, falling half above.
    assign w_u    = r_phase[C_PH_W-2 -: SMPL_W];
    assign w_tri  = r_phase[C_PH_W-1] ? SMPL_W'(TRI_POS - w_u) : SMPL_W'(w_u - TRI_OFS);
    assign w_prod = $signed(w_tri) * $signed({1'b0, r_env});

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            r_prod <= '0;
        end else if (r_tick_d1) begin
            r_prod <= SMPL_W'(w_prod >>> ENV_W);
        end
    end

    // Output stage: a new sample always loads; an unaccepted one being replaced flags overrun.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            r_smpl <= '0;
            r_vld  <= 1'b0;
            r_ovr  <= 1'b0;
        end else if (r_tick_d2) begin
            r_smpl <= MUTE_i ? '0 : r_prod;
            r_vld  <= 1'b1;
            if (r_vld && !SMPL_RDY_i) begin
                r_ovr <= 1'b1;
            end
        end else if (r_vld && SMPL_RDY_i) begin
            r_vld  <= 1'b0;
        end
    end

    assign SMPL_o     = r_smpl;
    assign SMPL_VLD_o = r_vld;
    assign OVR_o      = r_ovr;
    assign KEY_ON_o   = w_key_on;
    assign ENV_o      = r_env;
    assign STATE_o    = r_state;

endmodule

// File: tb/tb_an_tone_keyer.sv
// Bench for an_tone_keyer: directed scenarios plus randomized key/ready/mute traffic,
// all checked against an edge-level behavioural model of the keyer.
module tb_an_tone_keyer;

    localparam int TICK  = 10;
    localparam int STEP  = 64;
    localparam int PH_MOD = 16777216;
    localparam int INC   = $rtoi(7.0 * 16777216.0 / 100.0 + 0.5);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key = 1'b0;
    logic        mute = 1'b0;
    logic        rdy = 1'b1;
    logic [15:0] smpl;
    logic        vld;
    logic        ovr;
    logic        kon;
    logic [7:0]  env;
    logic [1:0]  st;

    int n_checks = 0;
    int n_errors = 0;

    an_tone_keyer #(
        .C_CK_Fs    (1000),
        .C_SMPL_Fs  (100),
        .C_TONE_Fs  (7),
        .C_PH_W     (24),
        .C_DEB_CKN  (4),
        .C_ENV_STEP (STEP)
    ) dut (
        .CK_i       (clk),
        .XARST_i    (rst_n),
        .KEY_i      (key),
        .MUTE_i     (mute),
        .SMPL_o     (smpl),
        .SMPL_VLD_o (vld),
        .SMPL_RDY_i (rdy),
        .OVR_o      (ovr),
        .KEY_ON_o   (kon),
        .ENV_o      (env),
        .STATE_o    (st)
    );

    always #5 clk = ~clk;

    // Reference model state (0 idle, 1 attack, 2 sustain, 3 release)
    int     m_cyc, m_state, m_env, m_pend, m_smpl, m_n;
    longint m_phase;
    bit     m_vld, m_ovr, m_kon, m_kold, m_tog;
    bit     h[5];

    function automatic int exp_sample(longint ph, int e);
        int u, tri_v, p;
        u = int'((ph / 128) % 65536);
        if (ph < 64'd8388608) tri_v = u - 32768;
        else                  tri_v = 32767 - u;
        p = tri_v * e;
        if (p >= 0) return p / 256;
        return -((-p + 255) / 256);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc = 0; m_state = 0; m_env = 0; m_phase = 0; m_pend = 0; m_smpl = 0;
            m_vld = 0; m_ovr = 0; m_kon = 0;
            for (int i = 0; i < 5; i++) h[i] = 0;
        end else begin
            m_n = m_cyc + 1;
            m_kold = m_kon;
            // key accepted once the last four synced samples all disagree with it
            m_tog = (h[1] == h[2]) && (h[2] == h[3]) && (h[3] == h[4]) && (h[1] != m_kon);
            if ((m_n % TICK) == 2 && m_n >= 12) begin
                if (m_vld && !rdy) m_ovr = 1;
                m_smpl = mute ? 0 : m_pend;
                m_vld = 1;
            end else if (m_vld && rdy) begin
                m_vld = 0;
            end
            if ((m_n % TICK) == 0) begin
                case (m_state)
                    0: begin
                        m_env = 0; m_phase = 0;
                        if (m_kold) m_state = 1;
                    end
                    1: begin
                        m_phase = (m_phase + INC) % PH_MOD;
                        if (!m_kold) m_state = 3;
                        else begin
                            m_env = (m_env + STEP > 255) ? 255 : m_env + STEP;
                            if (m_env == 255) m_state = 2;
                        end
                    end
                    2: begin
                        m_phase = (m_phase + INC) % PH_MOD;
                        m_env = 255;
                        if (!m_kold) m_state = 3;
                    end
                    default: begin
                        m_phase = (m_phase + INC) % PH_MOD;
                        if (m_kold) m_state = 1;
                        else begin
                            m_env = (m_env - STEP < 0) ? 0 : m_env - STEP;
                            if (m_env == 0) begin m_state = 0; m_phase = 0; end
                        end
                    end
                endcase
                m_pend = exp_sample(m_phase, m_env);
            end
            if (m_tog) m_kon = ~m_kon;
            for (int i = 4; i > 0; i--) h[i] = h[i-1];
            h[0] = key;
            m_cyc = m_n;
        end
    end

    task automatic wait_tick();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((m_cyc % TICK) != 0 && k < 2 * TICK);
        if ((m_cyc % TICK) != 0) begin
            n_checks++; n_errors++;
            $display("FAIL wait_tick: no tick within %0d cycles (cyc=%0d)", k, m_cyc);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks += 7;
        if (smpl !== 16'd0) begin n_errors++; $display("FAIL rst_smpl got=%0d exp=0", smpl); end
        if (vld !== 1'b0)   begin n_errors++; $display("FAIL rst_vld got=%b exp=0", vld); end
        if (ovr !== 1'b0)   begin n_errors++; $display("FAIL rst_ovr got=%b exp=0", ovr); end
        if (kon !== 1'b0)   begin n_errors++; $display("FAIL rst_kon got=%b exp=0", kon); end
        if (env !== 8'd0)   begin n_errors++; $display("FAIL rst_env got=%0d exp=0", env); end
        if (st !== 2'd0)    begin n_errors++; $display("FAIL rst_state got=%0d exp=0", st); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        if (vld !== 1'b0) begin n_errors++; $display("FAIL post_rst_vld got=%b exp=0", vld); end
    endtask

    task automatic test_debounce();
        @(negedge clk); key = 1'b1;
        repeat (3) @(negedge clk); key = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (kon !== 1'b0) begin n_errors++; $display("FAIL glitch_kon cyc%0d got=%b exp=0", i, kon); end
        end
        key = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (kon !== 1'b0) begin n_errors++; $display("FAIL deb_early got=%b exp=0", kon); end
        @(negedge clk);
        n_checks++;
        if (kon !== 1'b1) begin n_errors++; $display("FAIL deb_accept got=%b exp=1", kon); end
    endtask

    task automatic test_attack();
        int exp_e[4] = '{64, 128, 192, 255};
        for (int i = 0; i < 3 && m_state != 1; i++) wait_tick();
        n_checks += 2;
        if (st !== 2'd1)  begin n_errors++; $display("FAIL atk_enter_state got=%0d exp=1", st); end
        if (env !== 8'd0) begin n_errors++; $display("FAIL atk_enter_env got=%0d exp=0", env); end
        for (int i = 0; i < 4; i++) begin
            wait_tick();
            n_checks += 2;
            if (env !== 8'(exp_e[i])) begin n_errors++; $display("FAIL atk_env%0d got=%0d exp=%0d", i, env, exp_e[i]); end
            if (st !== ((i == 3) ? 2'd2 : 2'd1)) begin n_errors++; $display("FAIL atk_state%0d got=%0d exp=%0d", i, st, (i == 3) ? 2 : 1); end
            @(negedge clk);
            n_checks++;
            if (vld !== 1'b0) begin n_errors++; $display("FAIL atk_early_vld%0d got=%b exp=0", i, vld); end
            @(negedge clk);
            n_checks += 2;
            if (vld !== 1'b1) begin n_errors++; $display("FAIL atk_vld%0d got=%b exp=1", i, vld); end
            if (smpl !== 16'(m_smpl)) begin n_errors++; $display("FAIL atk_smpl%0d got=%0d exp=%0d", i, $signed(smpl), m_smpl); end
        end
    endtask

    task automatic test_release_repress();
        @(negedge clk); key = 1'b0;
        for (int i = 0; i < 3 && m_state != 3; i++) wait_tick();
        n_checks += 2;
        if (st !== 2'd3)    begin n_errors++; $display("FAIL rel_enter_state got=%0d exp=3", st); end
        if (env !== 8'd255) begin n_errors++; $display("FAIL rel_enter_env got=%0d exp=255", env); end
        wait_tick();
        n_checks++;
        if (env !== 8'd191) begin n_errors++; $display("FAIL rel_env1 got=%0d exp=191", env); end
        wait_tick();
        n_checks++;
        if (env !== 8'd127) begin n_errors++; $display("FAIL rel_env2 got=%0d exp=127", env); end
        repeat (5) @(negedge clk);
        key = 1'b1;
        wait_tick();
        n_checks += 2;
        if (env !== 8'd63) begin n_errors++; $display("FAIL rel_env3 got=%0d exp=63", env); end
        if (st !== 2'd3)   begin n_errors++; $display("FAIL rel_state3 got=%0d exp=3", st); end
        wait_tick();
        n_checks += 2;
        if (st !== 2'd1)   begin n_errors++; $display("FAIL repress_state got=%0d exp=1", st); end
        if (env !== 8'd63) begin n_errors++; $display("FAIL repress_env_hold got=%0d exp=63", env); end
        wait_tick();
        n_checks += 2;
        if (env !== 8'd127) begin n_errors++; $display("FAIL repress_env got=%0d exp=127", env); end
        if (st !== 2'd1)    begin n_errors++; $display("FAIL repress_state2 got=%0d exp=1", st); end
    endtask

    task automatic test_full_release();
        int exp_e[4] = '{191, 127, 63, 0};
        for (int i = 0; i < 5 && m_state != 2; i++) wait_tick();
        n_checks++;
        if (st !== 2'd2) begin n_errors++; $display("FAIL full_sus_state got=%0d exp=2", st); end
        key = 1'b0;
        for (int i = 0; i < 3 && m_state != 3; i++) wait_tick();
        n_checks++;
        if (env !== 8'd255) begin n_errors++; $display("FAIL full_rel_env0 got=%0d exp=255", env); end
        for (int i = 0; i < 4; i++) begin
            wait_tick();
            n_checks++;
            if (env !== 8'(exp_e[i])) begin n_errors++; $display("FAIL full_rel_env%0d got=%0d exp=%0d", i + 1, env, exp_e[i]); end
        end
        n_checks++;
        if (st !== 2'd0) begin n_errors++; $display("FAIL full_rel_idle got=%0d exp=0", st); end
        repeat (2) @(negedge clk);
        n_checks += 2;
        if (smpl !== 16'd0) begin n_errors++; $display("FAIL idle_smpl got=%0d exp=0", $signed(smpl)); end
        if (vld !== 1'b1)   begin n_errors++; $display("FAIL idle_vld got=%b exp=1", vld); end
    endtask

    task automatic test_backpressure_mute();
        logic [15:0] first;
        key = 1'b1;
        for (int i = 0; i < 10 && m_state != 2; i++) wait_tick();
        wait_tick();
        rdy = 1'b0;
        repeat (2) @(negedge clk);
        first = smpl;
        n_checks += 3;
        if (smpl !== 16'(m_smpl)) begin n_errors++; $display("FAIL bp_first got=%0d exp=%0d", $signed(smpl), m_smpl); end
        if (vld !== 1'b1) begin n_errors++; $display("FAIL bp_vld got=%b exp=1", vld); end
        if (ovr !== 1'b0) begin n_errors++; $display("FAIL bp_ovr_early got=%b exp=0", ovr); end
        repeat (5) @(negedge clk);
        n_checks++;
        if (smpl !== 16'(m_smpl) || smpl !== first) begin n_errors++; $display("FAIL bp_hold got=%0d exp=%0d", $signed(smpl), m_smpl); end
        wait_tick();
        repeat (2) @(negedge clk);
        n_checks += 2;
        if (smpl !== 16'(m_smpl)) begin n_errors++; $display("FAIL bp_overwrite got=%0d exp=%0d", $signed(smpl), m_smpl); end
        if (ovr !== 1'b1) begin n_errors++; $display("FAIL bp_ovr got=%b exp=1", ovr); end
        rdy = 1'b1;
        @(negedge clk);
        n_checks += 2;
        if (vld !== 1'b0) begin n_errors++; $display("FAIL bp_accept_vld got=%b exp=0", vld); end
        if (ovr !== 1'b1) begin n_errors++; $display("FAIL bp_ovr_sticky got=%b exp=1", ovr); end
        mute = 1'b1;
        wait_tick();
        repeat (2) @(negedge clk);
        n_checks += 2;
        if (smpl !== 16'd0) begin n_errors++; $display("FAIL mute_smpl got=%0d exp=0", $signed(smpl)); end
        if (env !== 8'd255) begin n_errors++; $display("FAIL mute_env got=%0d exp=255", env); end
        mute = 1'b0;
        wait_tick();
        repeat (2) @(negedge clk);
        n_checks++;
        if (smpl !== 16'(m_smpl)) begin n_errors++; $display("FAIL unmute_smpl got=%0d exp=%0d", $signed(smpl), m_smpl); end
    endtask

    task automatic test_reset_mid_run();
        n_checks++;
        if (st !== 2'd2) begin n_errors++; $display("FAIL mid_pre_state got=%0d exp=2", st); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks += 6;
        if (st !== 2'd0)    begin n_errors++; $display("FAIL mid_state got=%0d exp=0", st); end
        if (env !== 8'd0)   begin n_errors++; $display("FAIL mid_env got=%0d exp=0", env); end
        if (ovr !== 1'b0)   begin n_errors++; $display("FAIL mid_ovr got=%b exp=0", ovr); end
        if (kon !== 1'b0)   begin n_errors++; $display("FAIL mid_kon got=%b exp=0", kon); end
        if (smpl !== 16'd0) begin n_errors++; $display("FAIL mid_smpl got=%0d exp=0", $signed(smpl)); end
        if (vld !== 1'b0)   begin n_errors++; $display("FAIL mid_vld got=%b exp=0", vld); end
        key = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            n_checks += 6;
            if (env !== 8'(m_env))    begin n_errors++; $display("FAIL rnd_env c%0d got=%0d exp=%0d", c, env, m_env); end
            if (st !== 2'(m_state))   begin n_errors++; $display("FAIL rnd_state c%0d got=%0d exp=%0d", c, st, m_state); end
            if (kon !== m_kon)        begin n_errors++; $display("FAIL rnd_kon c%0d got=%b exp=%b", c, kon, m_kon); end
            if (vld !== m_vld)        begin n_errors++; $display("FAIL rnd_vld c%0d got=%b exp=%b", c, vld, m_vld); end
            if (ovr !== m_ovr)        begin n_errors++; $display("FAIL rnd_ovr c%0d got=%b exp=%b", c, ovr, m_ovr); end
            if (smpl !== 16'(m_smpl)) begin n_errors++; $display("FAIL rnd_smpl c%0d got=%0d exp=%0d", c, $signed(smpl), m_smpl); end
            if (hold == 0) begin
                key  = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 60);
            end else begin
                hold--;
            end
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) mute = ~mute;
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_attack();
        test_release_repress();
        test_full_release();
        test_backpressure_mute();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
